wb_sram_responder: RTL and testbench

Wishbone responder that terminates the m2 data-bus master port (the arbitrated D$ / others traffic, including the `bl`/`bry` burst extension) and drives a single-port SRAM macro placed outside the cache. It decodes a byte-addressed window, converts single and burst Wishbone cycles into one SRAM command per beat, and returns `ack`, or `err` for out-of-window accesses. It holds SRAM commands in registers and sequences them with a small FSM and a beat counter.

---
 rtl/wb_sram_responder_if.sv | 24 ++
 rtl/wb_sram_responder.sv | 163 ++++++++++++++++
 tb/tb_wb_sram_responder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sram_responder_if.sv
// Wishbone data-bus bundle (m2 master port with bl/bry burst extension).
interface wb_sram_responder_if;
  logic [31:0] dat_w;  // master -> responder write data
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [9:0]  bl;
  logic        bry;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;  // responder -> master read data
  logic        ack;
  logic        err;

  modport master (
    output dat_w, adr, sel, bl, bry, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  dat_w, adr, sel, bl, bry, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone responder driving a single-port SRAM macro: one SRAM command per beat,
// bursts with wrap inside the window, err for out-of-window accesses.
module wb_sram_responder #(
  parameter int unsigned AW   = 9,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  wb_sram_responder_if.slave  wbs,
  output logic                sram_csb_o,
  output logic                sram_web_o,
  output logic [3:0]          sram_wmask_o,
  output logic [AW-1:0]       sram_addr_o,
  output logic [31:0]         sram_din_o,
  input  logic [31:0]         sram_dout_i
);

  typedef enum logic [2:0] {
    StIdle, StWcmd, StRcmd, StRwait, StRack, StGap, StErr, StTurn
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    beats_q, beats_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          csb_q, csb_d;
  logic          web_q, web_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   din_q, din_d;
  logic [31:0]   dat_q, dat_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic          in_window;
  logic          issue;
  logic          issue_we;

  // Byte lane bits of the address carry no information for a word SRAM.
  logic unused_adr;
  assign unused_adr = ^wbs.adr[1:0];

  assign in_window = (wbs.adr >> (AW + 2)) == (BASE >> (AW + 2));

  // Next-state and registered-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    we_d     = we_q;
    addr_d   = addr_q;
    csb_d    = 1'b1;
    web_d    = 1'b1;
    wmask_d  = wmask_q;
    din_d    = din_q;
    dat_d    = dat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    issue    = 1'b0;
    issue_we = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wbs.cyc && wbs.stb) begin
          if (in_window) begin
            addr_d   = wbs.adr[AW+1:2];
            we_d     = wbs.we;
            beats_d  = (wbs.bl == 10'd0) ? 10'd1 : wbs.bl;
            issue    = 1'b1;
            issue_we = wbs.we;
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end
      StWcmd, StRack: begin
        beats_d = beats_q - 10'd1;
        state_d = (beats_q == 10'd1) ? StTurn : StGap;
      end
      StRcmd: begin
        state_d = wbs.cyc ? StRwait : StTurn;
      end
      StRwait: begin
        // An aborted read still completes in the SRAM; its data is simply dropped.
        if (wbs.cyc) begin
          dat_d   = sram_dout_i;
          ack_d   = 1'b1;
          state_d = StRack;
        end else begin
          state_d = StTurn;
        end
      end
      StGap: begin
        if (!wbs.cyc) begin
          state_d = StTurn;
        end else if (wbs.stb && wbs.bry) begin
          addr_d   = addr_q + AW'(1);
          issue    = 1'b1;
          issue_we = we_q;
        end
      end
      StErr: begin
        state_d = StTurn;
      end
      StTurn: begin
        state_d = StIdle;
      end
    endcase

    // Write beats are acked in the same cycle the SRAM command is presented.
    if (issue) begin
      csb_d = 1'b0;
      if (issue_we) begin
        web_d   = 1'b0;
        wmask_d = wbs.sel;
        din_d   = wbs.dat_w;
        ack_d   = 1'b1;
        state_d = StWcmd;
      end else begin
        wmask_d = 4'h0;
        state_d = StRcmd;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      beats_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      din_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      din_q   <= din_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign sram_csb_o   = csb_q;
  assign sram_web_o   = web_q;
  assign sram_wmask_o = wmask_q;
  assign sram_addr_o  = addr_q;
  assign sram_din_o   = din_q;
  assign wbs.dat_r    = dat_q;
  assign wbs.ack      = ack_q;
  assign wbs.err      = err_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench for wb_sram_responder: SRAM model, command/ack scoreboard,
// one task per scenario.
module tb_wb_sram_responder;
  localparam int unsigned AW    = 9;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned WORDS = 1 << AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  wb_sram_responder_if wbs();

  logic          sram_csb, sram_web;
  logic [3:0]    sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din, sram_dout;

  wb_sram_responder #(.AW(AW), .BASE(BASE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wbs          (wbs),
    .sram_csb_o   (sram_csb),
    .sram_web_o   (sram_web),
    .sram_wmask_o (sram_wmask),
    .sram_addr_o  (sram_addr),
    .sram_din_o   (sram_din),
    .sram_dout_i  (sram_dout)
  );

  always #5 clk = ~clk;

  // SRAM macro model: command captured at the edge, read data valid next cycle.
  logic [31:0] mem [WORDS];
  logic [31:0] shadow [WORDS];

  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        end
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int n_cmd  = 0;
  int n_ack  = 0;
  int n_err  = 0;

  typedef struct {
    logic          web;
    logic [AW-1:0] addr;
    logic [3:0]    wmask;
    logic [31:0]   din;
  } cmd_t;

  typedef struct {
    logic        rd;
    logic [31:0] data;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];
  cmd_t mon_cmd;
  ack_t mon_ack;

  // Scoreboard: compare each SRAM command and each ack against queued expectations.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!sram_csb) begin
        n_cmd++;
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL sram_cmd: unexpected command web=%b addr=%0d, none expected",
                   sram_web, sram_addr);
        end else begin
          mon_cmd = cmd_q.pop_front();
          if (sram_web !== mon_cmd.web || sram_addr !== mon_cmd.addr ||
              (!mon_cmd.web && (sram_wmask !== mon_cmd.wmask || sram_din !== mon_cmd.din))) begin
            errors++;
            $display("FAIL sram_cmd: got web=%b addr=%0d wmask=%h din=%h, want web=%b addr=%0d wmask=%h din=%h",
                     sram_web, sram_addr, sram_wmask, sram_din,
                     mon_cmd.web, mon_cmd.addr, mon_cmd.wmask, mon_cmd.din);
          end
        end
      end
      if (wbs.ack) begin
        n_ack++;
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL wb_ack: unexpected ack dat_o=%h, none expected", wbs.dat_r);
        end else begin
          mon_ack = ack_q.pop_front();
          if (mon_ack.rd && wbs.dat_r !== mon_ack.data) begin
            errors++;
            $display("FAIL wb_rdata: got %h, want %h", wbs.dat_r, mon_ack.data);
          end
        end
      end
      if (wbs.err) n_err++;
      if (wbs.ack && wbs.err) begin
        checks++;
        errors++;
        $display("FAIL ack_err_excl: ack=1 err=1, want never both");
      end
    end
  end

  task automatic push_write(input int word, input logic [31:0] d, input logic [3:0] sel);
    cmd_t c;
    ack_t a;
    c.web = 1'b0; c.addr = AW'(word); c.wmask = sel; c.din = d;
    cmd_q.push_back(c);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) shadow[word][8*b +: 8] = d[8*b +: 8];
    end
    a.rd = 1'b0; a.data = 32'h0;
    ack_q.push_back(a);
  endtask

  task automatic push_read(input int word);
    cmd_t c;
    ack_t a;
    c.web = 1'b1; c.addr = AW'(word); c.wmask = 4'h0; c.din = 32'h0;
    cmd_q.push_back(c);
    a.rd = 1'b1; a.data = shadow[word];
    ack_q.push_back(a);
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] d,
                       input logic [3:0] sel, input logic [9:0] bl);
    wbs.we = we; wbs.adr = adr; wbs.dat_w = d; wbs.sel = sel; wbs.bl = bl;
    wbs.bry = 1'b1; wbs.cyc = 1'b1; wbs.stb = 1'b1;
  endtask

  task automatic release_bus();
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.bry = 1'b0;
  endtask

  // Single access; lat counts cycles after the accepting cycle until ack/err (-1 on timeout).
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] d,
                           input logic [3:0] sel, output int lat, output logic [31:0] rdat,
                           output logic got_err);
    lat = -1; rdat = 32'h0; got_err = 1'b0;
    drive(we, adr, d, sel, 10'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wbs.ack || wbs.err) begin
        lat = c; rdat = wbs.dat_r; got_err = wbs.err;
        break;
      end
    end
    @(posedge clk); #1;
    release_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    logic [31:0] rd;
    logic e;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sram_csb !== 1'b1 || sram_web !== 1'b1 || sram_wmask !== 4'h0 || sram_addr !== '0 ||
        sram_din !== 32'h0 || wbs.dat_r !== 32'h0 || wbs.ack !== 1'b0 || wbs.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: csb=%b web=%b wmask=%h addr=%0d din=%h dat=%h ack=%b err=%b, want 1 1 0 0 0 0 0 0",
               sram_csb, sram_web, sram_wmask, sram_addr, sram_din, wbs.dat_r, wbs.ack, wbs.err);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    push_write(8, 32'hCAFEF00D, 4'hF);
    wb_access(1'b1, BASE + 32'h20, 32'hCAFEF00D, 4'hF, lat, rd, e);
    push_read(8);
    wb_access(1'b0, BASE + 32'h20, 32'h0, 4'hF, lat, rd, e);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_preread: got %h, want cafef00d", rd);
    end
    // Start another read and pull reset in the middle of RWAIT.
    push_read(8);
    drive(1'b0, BASE + 32'h20, 32'h0, 4'hF, 10'd0);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (sram_csb !== 1'b1 || wbs.ack !== 1'b0 || wbs.dat_r !== 32'h0 || sram_addr !== '0 ||
        sram_web !== 1'b1 || wbs.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: csb=%b ack=%b dat=%h addr=%0d web=%b err=%b, want 1 0 0 0 1 0",
               sram_csb, wbs.ack, wbs.dat_r, sram_addr, sram_web, wbs.err);
    end
    release_bus();
    checks++;
    if (ack_q.size() != 1 || cmd_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending: ack_q=%0d cmd_q=%0d, want 1 0", ack_q.size(), cmd_q.size());
    end
    ack_q.delete();
    cmd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    push_read(8);
    wb_access(1'b0, BASE + 32'h20, 32'h0, 4'hF, lat, rd, e);
    checks++;
    if (lat != 3 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_after: lat=%0d dat=%h, want lat=3 dat=cafef00d", lat, rd);
    end
  endtask

  task automatic test_single_write_read();
    int lat;
    logic [31:0] rd;
    logic e;
    push_write(4, 32'hDEADBEEF, 4'hF);
    wb_access(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e);
    checks++;
    if (lat != 1 || e !== 1'b0) begin
      errors++;
      $display("FAIL write_latency: lat=%0d err=%b, want lat=1 err=0", lat, e);
    end
    push_read(4);
    wb_access(1'b0, BASE + 32'h10, 32'h0, 4'h0, lat, rd, e);
    checks++;
    if (lat != 3 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_latency: lat=%0d dat=%h, want lat=3 dat=deadbeef", lat, rd);
    end
  endtask

  task automatic test_byte_write();
    int lat;
    logic [31:0] rd;
    logic e;
    push_write(4, 32'h0000AB00, 4'h2);
    wb_access(1'b1, BASE + 32'h10, 32'h0000AB00, 4'h2, lat, rd, e);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL byte_write_latency: lat=%0d, want 1", lat);
    end
    push_read(4);
    wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, lat, rd, e);
    checks++;
    if (rd !== 32'hDEADABEF) begin
      errors++;
      $display("FAIL byte_write_merge: got %h, want deadabef", rd);
    end
  endtask

  task automatic test_burst_read_wrap();
    int cmd_c[4];
    int ack_c[4];
    int nc = 0;
    int na = 0;
    int stall = 0;
    for (int i = 0; i < 4; i++) begin cmd_c[i] = -1; ack_c[i] = -1; end
    push_read(510); push_read(511); push_read(0); push_read(1);
    drive(1'b0, BASE + 32'h7F8, 32'h0, 4'hF, 10'd4);
    for (int c = 0; c < 60 && na < 4; c++) begin
      @(negedge clk);
      if (!sram_csb && nc < 4) begin cmd_c[nc] = c; nc++; end
      if (wbs.ack && na < 4) begin ack_c[na] = c; na++; end
      @(posedge clk); #1;
      if (stall > 0) begin
        stall--;
        if (stall == 0) wbs.bry = 1'b1;
      end else if (na == 2 && ack_c[1] == c) begin
        wbs.bry = 1'b0;
        stall = 2;
      end
    end
    release_bus();
    @(posedge clk); #1;
    checks++;
    if (na != 4 || nc != 4) begin
      errors++;
      $display("FAIL burst_count: acks=%0d cmds=%0d, want 4 4", na, nc);
    end
    checks++;
    if (cmd_c[0] != 1 || cmd_c[1] - cmd_c[0] != 4 || ack_c[0] != 3) begin
      errors++;
      $display("FAIL burst_spacing: cmd0=%0d cmd1=%0d ack0=%0d, want 1 5 3",
               cmd_c[0], cmd_c[1], ack_c[0]);
    end
    checks++;
    if (cmd_c[2] - ack_c[1] != 4) begin
      errors++;
      $display("FAIL burst_stall: beat3 cmd %0d cycles after ack2, want 4", cmd_c[2] - ack_c[1]);
    end
  endtask

  task automatic test_out_of_window();
    logic [5:0] err_seen = '0;
    int err0 = n_err;
    drive(1'b0, BASE + 32'h800, 32'h0, 4'hF, 10'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      err_seen[c] = wbs.err;
      @(posedge clk); #1;
      if (c == 2) release_bus();
    end
    checks++;
    if (err_seen !== 6'b000010) begin
      errors++;
      $display("FAIL oow_err_timing: err per cycle=%b, want 000010", err_seen);
    end
    checks++;
    if (n_err - err0 != 1) begin
      errors++;
      $display("FAIL oow_err_count: got %0d, want 1", n_err - err0);
    end
  endtask

  task automatic test_burst_abort();
    int cmd0 = n_cmd;
    int ack0 = n_ack;
    int na = 0;
    int lat;
    logic [31:0] rd;
    logic e;
    push_write(16, 32'h11112222, 4'hF);
    push_write(17, 32'h33334444, 4'hC);
    drive(1'b1, BASE + 32'h40, 32'h11112222, 4'hF, 10'd4);
    for (int c = 0; c < 30 && na < 2; c++) begin
      @(negedge clk);
      if (wbs.ack) na++;
      @(posedge clk); #1;
      if (na == 1) begin wbs.dat_w = 32'h33334444; wbs.sel = 4'hC; end
    end
    release_bus();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (n_cmd - cmd0 != 2 || n_ack - ack0 != 2) begin
      errors++;
      $display("FAIL abort_counts: cmds=%0d acks=%0d, want 2 2", n_cmd - cmd0, n_ack - ack0);
    end
    push_read(17);
    wb_access(1'b0, BASE + 32'h44, 32'h0, 4'hF, lat, rd, e);
    checks++;
    if (lat != 3 || rd !== 32'h33330011) begin
      errors++;
      $display("FAIL abort_followup: lat=%0d dat=%h, want lat=3 dat=33330011", lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    int ack_c[2];
    int na = 0;
    int rcmd_c = -1;
    ack_c[0] = -1; ack_c[1] = -1;
    push_write(30, 32'h0BADF00D, 4'hF);
    push_read(30);
    drive(1'b1, BASE + 32'h78, 32'h0BADF00D, 4'hF, 10'd0);
    for (int c = 0; c < 20 && na < 2; c++) begin
      @(negedge clk);
      if (!sram_csb && sram_web && rcmd_c < 0) rcmd_c = c;
      if (wbs.ack && na < 2) begin ack_c[na] = c; na++; end
      @(posedge clk); #1;
      if (na == 1) wbs.we = 1'b0;
    end
    release_bus();
    @(posedge clk); #1;
    checks++;
    if (na != 2 || ack_c[0] != 1 || rcmd_c != 4 || ack_c[1] != 6) begin
      errors++;
      $display("FAIL back_to_back: acks=%0d wack=%0d rcmd=%0d rack=%0d, want 2 1 4 6",
               na, ack_c[0], rcmd_c, ack_c[1]);
    end
  endtask

  initial begin
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0; wbs.adr = 32'h0;
    wbs.dat_w = 32'h0; wbs.sel = 4'h0; wbs.bl = 10'd0; wbs.bry = 1'b0;
    for (int i = 0; i < int'(WORDS); i++) begin
      mem[i] = 32'h5A00_0000 | i;
      shadow[i] = 32'h5A00_0000 | i;
    end
    test_reset();
    test_single_write_read();
    test_byte_write();
    test_burst_read_wrap();
    test_out_of_window();
    test_burst_abort();
    test_back_to_back();
    checks++;
    if (cmd_q.size() != 0 || ack_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: cmd_q=%0d ack_q=%0d left, want 0 0",
               cmd_q.size(), ack_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
